// File: rtl/frame_monitor.sv
// ---------------------------------------------------------------------------
// frame_monitor
//
// Traffic sink and monitor at the tail of the packet-filter datapath. Accepts
// an AXI-Stream frame stream of 16-bit beats and:
//   - compares the destination MAC against NUM_FILTERS programmable entries,
//   - accumulates a payload checksum from beat PAYLOAD_OFFSET onward,
//   - flags runt frames (last beat before the payload offset),
//   - enforces a programmable inter-frame gap by dropping tready,
//   - keeps saturating 8-bit frame / match / runt counters.
// Software configures and reads the block through an 8-bit Avalon-MM slave.
//
// Ports:
//   clk                  clock
//   reset                asynchronous, active-low reset
//   writedata/write      Avalon write data / strobe
//   chipselect           Avalon chip select
//   address              Avalon register address
//   read/readdata        Avalon read strobe / registered read data
//   ingress_port_tdata   stream beat
//   ingress_port_tvalid  beat valid
//   ingress_port_tready  block ready (low during the inter-frame gap)
//   ingress_port_tlast   last beat of frame
//   frame_irq            one-cycle pulse per completed frame
//
// Register map:
//   6k+b  filter k, MAC byte b (RW)   0x30 filter enable mask (RW)
//   0x31  inter-frame wait (RW)       0x32 control, bit0 clears counters (W)
//   0x38  status {0, idx[2:0], 00, runt, matched} (R)
//   0x39..0x3C last checksum bytes 0..3 (R)
//   0x3D frame count, 0x3E match count, 0x3F runt count (R)
// ---------------------------------------------------------------------------
module frame_monitor #(
    parameter int NUM_FILTERS    = 4,
    parameter int PREAMBLE_BEATS = 3,
    parameter int PAYLOAD_OFFSET = 10,
    parameter int CSUM_WIDTH     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  writedata,
    input  logic        write,
    input  logic        chipselect,
    input  logic [7:0]  address,
    input  logic        read,
    output logic [7:0]  readdata,
    input  logic [15:0] ingress_port_tdata,
    input  logic        ingress_port_tvalid,
    output logic        ingress_port_tready,
    input  logic        ingress_port_tlast,
    output logic        frame_irq
);

    localparam int NUM_MAC_BYTES = 6 * NUM_FILTERS;
    localparam int CSUM_BYTES    = CSUM_WIDTH / 8;

    localparam logic [7:0] ADDR_ENABLE  = 8'h30;
    localparam logic [7:0] ADDR_WAIT    = 8'h31;
    localparam logic [7:0] ADDR_CTRL    = 8'h32;
    localparam logic [7:0] ADDR_STATUS  = 8'h38;
    localparam logic [7:0] ADDR_CSUM0   = 8'h39;
    localparam logic [7:0] ADDR_FRAMES  = 8'h3D;
    localparam logic [7:0] ADDR_MATCHES = 8'h3E;
    localparam logic [7:0] ADDR_RUNTS   = 8'h3F;

    typedef enum logic {
        RECV,
        GAP
    } state_t;

    state_t state, state_next;

    // Configuration registers
    logic [7:0]             mac [NUM_MAC_BYTES];
    logic [NUM_FILTERS-1:0] enable;
    logic [7:0]             wait_cfg;

    // Per-frame working state
    logic [7:0]             gap_cnt;
    logic [7:0]             beat_idx;
    logic [NUM_FILTERS-1:0] hits;
    logic [CSUM_WIDTH-1:0]  csum;

    // Snapshots and statistics
    logic [CSUM_WIDTH-1:0]  csum_last;
    logic [7:0]             status;
    logic [7:0]             frame_count;
    logic [7:0]             match_count;
    logic [7:0]             runt_count;

    // Derived strobes
    logic                   reg_wr;
    logic                   clear;
    logic                   beat_hs;
    logic                   frame_end;
    logic                   frame_start;

    // Beat evaluation results
    logic [NUM_FILTERS-1:0] hits_next;
    logic [NUM_FILTERS-1:0] match_vec;
    logic [2:0]             match_idx;
    logic                   compare_done;
    logic                   matched;
    logic                   runt;
    logic [CSUM_WIDTH-1:0]  csum_base;
    logic [CSUM_WIDTH-1:0]  csum_next;
    logic [7:0]             status_next;
    logic [31:0]            csum_ext;
    logic [7:0]             rd_mux;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign reg_wr      = chipselect && write;
    assign clear       = reg_wr && (address == ADDR_CTRL) && writedata[0];
    assign ingress_port_tready = (state == RECV);
    assign beat_hs     = ingress_port_tvalid && ingress_port_tready;
    assign frame_end   = beat_hs && ingress_port_tlast;
    assign frame_start = (beat_idx == 8'd0);

    // -----------------------------------------------------------------------
    // Configuration registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the MAC table is a handful of flops, not a RAM, so it is
            // reset along with everything else and always reads back defined.
            for (int i = 0; i < NUM_MAC_BYTES; i++) mac[i] <= '0;
            enable   <= '0;
            wait_cfg <= '0;
        end else if (reg_wr) begin
            for (int i = 0; i < NUM_MAC_BYTES; i++)
                if (address == 8'(i)) mac[i] <= writedata;
            if (address == ADDR_ENABLE) enable   <= writedata[NUM_FILTERS-1:0];
            if (address == ADDR_WAIT)   wait_cfg <= writedata;
        end
    end

    // -----------------------------------------------------------------------
    // Receive / gap state machine
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RECV;
        else        state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            RECV: if (frame_end && wait_cfg != 8'd0) state_next = GAP;
            GAP:  if (gap_cnt == 8'd1)              state_next = RECV;
            default: state_next = RECV;
        endcase
    end

    // gap_cnt holds N..1 across the N idle cycles of the gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            gap_cnt <= '0;
        else if (frame_end)    gap_cnt <= wait_cfg;
        else if (state == GAP) gap_cnt <= gap_cnt - 8'd1;
    end

    // -----------------------------------------------------------------------
    // Per-beat evaluation: MAC compare, checksum, completion status
    // -----------------------------------------------------------------------
    always_comb begin
        // Hit bits restart as all-ones on the first beat of every frame; the
        // filter bytes are read live so mid-frame writes take effect.
        hits_next = frame_start ? '1 : hits;
        for (int k = 0; k < NUM_FILTERS; k++)
            for (int j = 0; j < 3; j++)
                if (beat_idx == 8'(PREAMBLE_BEATS + j) &&
                    ingress_port_tdata != {mac[6*k+2*j+1], mac[6*k+2*j]})
                    hits_next[k] = 1'b0;

        match_vec    = hits_next & enable;
        compare_done = (beat_idx >= 8'(PREAMBLE_BEATS + 2));
        matched      = compare_done && (|match_vec);
        runt         = (beat_idx < 8'(PAYLOAD_OFFSET));

        // Scan downward so the lowest matching index wins.
        match_idx = '0;
        for (int k = NUM_FILTERS - 1; k >= 0; k--)
            if (match_vec[k]) match_idx = 3'(k);

        status_next = {1'b0, (matched ? match_idx : 3'd0), 2'b00, runt, matched};

        csum_base = frame_start ? '0 : csum;
        csum_next = csum_base;
        if (beat_idx >= 8'(PAYLOAD_OFFSET))
            csum_next = csum_base + CSUM_WIDTH'(ingress_port_tdata);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_idx <= '0;
            hits     <= '0;
            csum     <= '0;
        end else if (beat_hs) begin
            hits <= hits_next;
            csum <= csum_next;
            if (ingress_port_tlast)      beat_idx <= '0;
            else if (beat_idx != 8'hFF)  beat_idx <= beat_idx + 8'd1;
        end
    end

    // Snapshots follow every completed frame, even when a clear lands on the
    // same cycle; the clear only wins for the counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_last <= '0;
            status    <= '0;
        end else if (frame_end) begin
            csum_last <= csum_next;
            status    <= status_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count <= '0;
            match_count <= '0;
            runt_count  <= '0;
        end else if (clear) begin
            frame_count <= '0;
            match_count <= '0;
            runt_count  <= '0;
        end else if (frame_end) begin
            frame_count <= sat_inc(frame_count);
            if (matched) match_count <= sat_inc(match_count);
            if (runt)    runt_count  <= sat_inc(runt_count);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) frame_irq <= 1'b0;
        else        frame_irq <= frame_end;
    end

    // -----------------------------------------------------------------------
    // Avalon read path
    // -----------------------------------------------------------------------
    assign csum_ext = 32'(csum_last);

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_MAC_BYTES; i++)
            if (address == 8'(i)) rd_mux = mac[i];
        // Bytes beyond the configured checksum width read as zero.
        for (int n = 0; n < 4; n++)
            if (address == ADDR_CSUM0 + 8'(n) && n < CSUM_BYTES)
                rd_mux = csum_ext[8*n +: 8];
        case (address)
            ADDR_ENABLE:  rd_mux = 8'(enable);
            ADDR_WAIT:    rd_mux = wait_cfg;
            ADDR_STATUS:  rd_mux = status;
            ADDR_FRAMES:  rd_mux = frame_count;
            ADDR_MATCHES: rd_mux = match_count;
            ADDR_RUNTS:   rd_mux = runt_count;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) readdata <= '0;
        else        readdata <= (chipselect && read) ? rd_mux : 8'h00;
    end

endmodule

// File: tb/tb_frame_monitor.sv
// ---------------------------------------------------------------------------
// tb_frame_monitor
//
// Self-checking bench for frame_monitor. Directed steps and randomized frames
// run in one initial block; expected status, checksum and counter values come
// from a frame-level model that looks at a whole frame as a queue of beats
// (48-bit destination MAC compare, arithmetic payload sum, length-based runt).
// ---------------------------------------------------------------------------
module tb_frame_monitor;

    localparam int NF   = 4;
    localparam int PRE  = 3;
    localparam int POFF = 10;
    localparam int CW   = 32;

    localparam logic [47:0] MAC1 = 48'h5544_3322_1102;  // 02:11:22:33:44:55

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic [7:0]  writedata  = '0;
    logic        write      = 1'b0;
    logic        chipselect = 1'b0;
    logic [7:0]  address    = '0;
    logic        read       = 1'b0;
    logic [7:0]  readdata;
    logic [15:0] tdata      = '0;
    logic        tvalid     = 1'b0;
    logic        tlast      = 1'b0;
    logic        tready;
    logic        frame_irq;

    always #5 clk = ~clk;

    frame_monitor #(
        .NUM_FILTERS   (NF),
        .PREAMBLE_BEATS(PRE),
        .PAYLOAD_OFFSET(POFF),
        .CSUM_WIDTH    (CW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .writedata          (writedata),
        .write              (write),
        .chipselect         (chipselect),
        .address            (address),
        .read               (read),
        .readdata           (readdata),
        .ingress_port_tdata (tdata),
        .ingress_port_tvalid(tvalid),
        .ingress_port_tready(tready),
        .ingress_port_tlast (tlast),
        .frame_irq          (frame_irq)
    );

    int total     = 0;
    int bad       = 0;
    int irq_count = 0;

    always @(posedge clk) if (frame_irq === 1'b1) irq_count++;

    // Reference model state
    logic [7:0]    tb_mac [6*NF];
    logic [NF-1:0] tb_en;
    int            exp_frames;
    int            exp_matches;
    int            exp_runts;
    int            exp_irq;
    logic [7:0]    exp_status;
    logic [31:0]   exp_csum;

    logic [15:0]   frame_q[$];
    logic [15:0]   directed_q[$];
    int            stall_first;
    logic          irq_at_end;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus access ----------------
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    // Register write that also updates the model's view of the configuration.
    task automatic prog(input logic [7:0] a, input logic [7:0] d);
        bus_write(a, d);
        if (int'(a) < 6*NF) tb_mac[int'(a)] = d;
        else if (a == 8'h30) tb_en = d[NF-1:0];
        else if (a == 8'h32 && d[0]) begin
            exp_frames = 0; exp_matches = 0; exp_runts = 0;
        end
    endtask

    task automatic set_filter(input int k, input logic [47:0] m);
        for (int b = 0; b < 6; b++) prog(8'(6*k + b), m[8*b +: 8]);
    endtask

    task automatic check_reg(input string tag, input logic [7:0] a, input logic [7:0] e);
        logic [7:0] d;
        bus_read(a, d);
        check(tag, 32'(d), 32'(e));
    endtask

    // ---------------- reference model ----------------
    function automatic logic [47:0] filter_mac(input int k);
        logic [47:0] m;
        for (int b = 0; b < 6; b++) m[8*b +: 8] = tb_mac[6*k + b];
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6*NF; i++) tb_mac[i] = '0;
        tb_en = '0;
        exp_frames = 0; exp_matches = 0; exp_runts = 0;
        exp_status = '0; exp_csum = '0;
    endtask

    // Whole-frame view: destination MAC is beats PRE..PRE+2, payload is every
    // beat from POFF on, and a runt is a frame whose last beat precedes POFF.
    task automatic model_frame();
        int          len;
        int          idx;
        bit          hit;
        bit          is_runt;
        logic [31:0] sum;
        logic [47:0] dest;
        len = frame_q.size();
        sum = '0; hit = 0; idx = 0;
        for (int i = POFF; i < len; i++) sum = sum + 32'(frame_q[i]);
        if (len >= PRE + 3) begin
            dest = {frame_q[PRE+2], frame_q[PRE+1], frame_q[PRE]};
            for (int k = NF - 1; k >= 0; k--)
                if (tb_en[k] && dest == filter_mac(k)) begin hit = 1; idx = k; end
        end
        is_runt    = (len - 1) < POFF;
        exp_status = {1'b0, 3'(idx), 2'b00, is_runt, hit};
        exp_csum   = sum;
        if (exp_frames < 255)           exp_frames++;
        if (hit && exp_matches < 255)   exp_matches++;
        if (is_runt && exp_runts < 255) exp_runts++;
        exp_irq++;
    endtask

    task automatic make_frame(input int len, input logic [47:0] dmac);
        frame_q.delete();
        for (int i = 0; i < len; i++)
            if (i >= PRE && i < PRE + 3) frame_q.push_back(dmac[16*(i-PRE) +: 16]);
            else                         frame_q.push_back(16'($urandom));
    endtask

    // Sends frame_q (or only its first stop_at beats when stop_at > 0).
    // Returns on the falling edge after the last handshake, tvalid dropped.
    task automatic send_frame(input bit toggle, input int stop_at);
        int n;
        int last;
        last = (stop_at > 0) ? stop_at : frame_q.size();
        stall_first = 0;
        for (int i = 0; i < last; i++) begin
            @(negedge clk);
            if (toggle && i > 0) begin
                tvalid = 1'b0; tlast = 1'b0;
                @(negedge clk);
            end
            tdata  = frame_q[i];
            tvalid = 1'b1;
            tlast  = (i == frame_q.size() - 1);
            n = 0;
            while (tready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
            if (i == 0) stall_first = n;
            if (n >= 100) check("tready_timeout", 32'(tready), 32'd1);
        end
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
        irq_at_end = frame_irq;
    endtask

    task automatic check_results(input string tag);
        logic [7:0]  d;
        logic [31:0] cs;
        bus_read(8'h38, d);
        check({tag, ":status"}, 32'(d), 32'(exp_status));
        cs = '0;
        for (int b = 0; b < 4; b++) begin
            bus_read(8'(8'h39 + b), d);
            cs[8*b +: 8] = d;
        end
        check({tag, ":csum"}, cs, exp_csum);
        bus_read(8'h3D, d);
        check({tag, ":frames"}, 32'(d), 32'(exp_frames));
        bus_read(8'h3E, d);
        check({tag, ":matches"}, 32'(d), 32'(exp_matches));
        bus_read(8'h3F, d);
        check({tag, ":runts"}, 32'(d), 32'(exp_runts));
        check({tag, ":irqs"}, 32'(irq_count), 32'(exp_irq));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int          n;
        int          sel;
        logic [47:0] dmac;
        logic [47:0] rmac;

        model_reset();
        exp_irq = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tready",   32'(tready),    32'd1);
        check("rst_readdata", 32'(readdata),  32'd0);
        check("rst_irq",      32'(frame_irq), 32'd0);
        reset = 1'b1;
        check_results("reset");

        // Matching 12-beat frame on filter 1
        set_filter(1, MAC1);
        prog(8'h30, 8'h02);
        prog(8'h31, 8'h00);
        make_frame(12, MAC1);
        frame_q[10] = 16'h0001;
        frame_q[11] = 16'hFFFF;
        directed_q = frame_q;
        send_frame(1'b0, 0);
        check("t1_irq_pulse", 32'(irq_at_end), 32'd1);
        @(negedge clk);
        check("t1_irq_single", 32'(frame_irq), 32'd0);
        check("idle_readdata", 32'(readdata), 32'd0);
        model_frame();
        check_results("t1");
        check_reg("t1_status_lit", 8'h38, 8'h11);
        check_reg("t1_csum_b2_lit", 8'h3B, 8'h01);

        // Same frame, filters disabled
        prog(8'h30, 8'h00);
        frame_q = directed_q;
        send_frame(1'b0, 0);
        model_frame();
        check_results("t2");
        check_reg("t2_status_lit", 8'h38, 8'h00);

        // Inter-frame gap of 5 cycles
        prog(8'h30, 8'h02);
        prog(8'h31, 8'h05);
        frame_q = directed_q;
        send_frame(1'b0, 0);
        model_frame();
        n = 0;
        while (tready !== 1'b1 && n < 50) begin n++; @(negedge clk); end
        check("gap_len", 32'(n), 32'd5);
        check("gap_ready_after", 32'(tready), 32'd1);
        check_results("gap1");

        // A beat presented during the gap is taken on the first ready cycle
        send_frame(1'b0, 0);
        model_frame();
        send_frame(1'b0, 0);
        check("gap_held_stall", 32'(stall_first), 32'd4);
        model_frame();
        check_results("gap2");
        prog(8'h31, 8'h00);

        // Runt with a complete, matching MAC
        make_frame(6, MAC1);
        send_frame(1'b0, 0);
        model_frame();
        check_results("runt");
        check_reg("runt_status_lit", 8'h38, 8'h13);

        // Bubbles on tvalid do not change the checksum
        frame_q = directed_q;
        send_frame(1'b1, 0);
        model_frame();
        check_results("toggle");
        check_reg("toggle_csum_b2_lit", 8'h3B, 8'h01);

        // Randomized frames; filters 2 and 3 share a MAC so the lowest
        // enabled index must be reported.
        rmac = {16'($urandom), 32'($urandom)};
        set_filter(0, {16'($urandom), 32'($urandom)});
        set_filter(2, rmac);
        set_filter(3, rmac);
        for (int f = 0; f < 24; f++) begin
            prog(8'h30, 8'($urandom_range(0, 15)));
            prog(8'h31, 8'($urandom_range(0, 3)));
            sel = $urandom_range(0, 4);
            dmac = (sel < 4) ? filter_mac(sel) : {16'($urandom), 32'($urandom)};
            make_frame($urandom_range(1, 24), dmac);
            send_frame(1'($urandom_range(0, 1)), 0);
            model_frame();
            check_results("rand");
        end
        prog(8'h31, 8'h00);

        // Counter saturation
        for (int f = 0; f < 300; f++) begin
            make_frame($urandom_range(1, 4), {16'($urandom), 32'($urandom)});
            send_frame(1'b0, 0);
            model_frame();
        end
        check_results("sat");
        check_reg("sat_frames_lit", 8'h3D, 8'hFF);

        // Clear
        prog(8'h32, 8'h01);
        check_results("clear");
        check_reg("clear_frames_lit", 8'h3D, 8'h00);

        // Reset in the middle of a frame
        set_filter(1, MAC1);
        prog(8'h30, 8'h02);
        frame_q = directed_q;
        send_frame(1'b0, 7);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check_results("midreset");
        check_reg("midreset_mac", 8'h06, 8'h00);
        check_reg("midreset_en",  8'h30, 8'h00);

        // Next full frame after reset
        set_filter(1, MAC1);
        prog(8'h30, 8'h02);
        frame_q = directed_q;
        send_frame(1'b0, 0);
        model_frame();
        check_results("post_reset");
        check_reg("post_reset_status_lit", 8'h38, 8'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
